// File: rtl/hp48_bus_ctrl.sv
// rtl/hp48_bus_ctrl.sv - nibble-serial read/write transfer sequencer in front of hp48_bus
// Optional feature macro: HP48_BUS_CTRL_ERR_ABORT_EN (bus error ends the transfer early)
module hp48_bus_ctrl (
   input  logic        i_strobe,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic [1:0]  i_req_op,
   input  logic [19:0] i_req_addr,
   input  logic [3:0]  i_req_len,
   input  logic [63:0] i_req_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [63:0] o_rd_data,
   output logic [19:0] o_bus_address,
   output logic [3:0]  o_bus_command,
   output logic [3:0]  o_bus_nibble_in,
   input  logic [3:0]  i_bus_nibble_out,
   input  logic        i_bus_error
);

   // Command encodings shared with hp48_bus (bus_commands.v)
   localparam logic [3:0] BUSCMD_NOP      = 4'h0;
   localparam logic [3:0] BUSCMD_PC_READ  = 4'h1;
   localparam logic [3:0] BUSCMD_DP_READ  = 4'h2;
   localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;

   localparam logic [1:0] OP_PC_READ  = 2'b00;
   localparam logic [1:0] OP_DP_READ  = 2'b01;
   localparam logic [1:0] OP_DP_WRITE = 2'b10;
   localparam logic [1:0] OP_RSVD     = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_XFER = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [1:0]  r_op_q;
   logic [19:0] r_base_q;
   logic [3:0]  r_len_q;
   logic [3:0]  r_idx;
   logic [63:0] r_wdata_q;
   logic [63:0] r_rd_data;
   logic        r_err_q;

   logic        w_accept;
   logic        w_last;
   logic [3:0]  w_wr_nibble;

   assign w_accept    = (r_state == S_IDLE) && i_req;
   assign w_last      = (r_idx == r_len_q);
   assign w_wr_nibble = r_wdata_q[{r_idx, 2'b00} +: 4];
   assign o_rd_data   = r_rd_data;

   // State register; reset drops any in-flight transfer without a done pulse
   always_ff @(posedge i_strobe or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: reserved op skips the bus entirely and reports done
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               w_next_state = (i_req_op == OP_RSVD) ? S_DONE : S_XFER;
            end
         end
         S_XFER: begin
`ifdef HP48_BUS_CTRL_ERR_ABORT_EN
            if (w_last || i_bus_error) begin
               w_next_state = S_DONE;
            end
`else
            if (w_last) begin
               w_next_state = S_DONE;
            end
`endif
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs: bus signals are combinational from registered state
   always_comb begin
      o_busy          = (r_state != S_IDLE);
      o_done          = 1'b0;
      o_error         = 1'b0;
      o_bus_address   = 20'h00000;
      o_bus_command   = BUSCMD_NOP;
      o_bus_nibble_in = 4'h0;
      case (r_state)
         S_XFER: begin
            // 20-bit sum wraps 0xFFFFF+1 to 0x00000 naturally
            o_bus_address = r_base_q + {16'h0000, r_idx};
            case (r_op_q)
               OP_PC_READ:  o_bus_command = BUSCMD_PC_READ;
               OP_DP_READ:  o_bus_command = BUSCMD_DP_READ;
               OP_DP_WRITE: o_bus_command = BUSCMD_DP_WRITE;
               default:     o_bus_command = BUSCMD_NOP;
            endcase
            if (r_op_q == OP_DP_WRITE) begin
               o_bus_nibble_in = w_wr_nibble;
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            o_error = r_err_q;
         end
         default: begin
            o_done = 1'b0;
         end
      endcase
   end

   // Request latch, nibble index, read assembly and sticky error flag
   always_ff @(posedge i_strobe or negedge i_reset) begin
      if (!i_reset) begin
         r_op_q    <= 2'b00;
         r_base_q  <= 20'h00000;
         r_len_q   <= 4'h0;
         r_idx     <= 4'h0;
         r_wdata_q <= 64'h0;
         r_rd_data <= 64'h0;
         r_err_q   <= 1'b0;
      end else if (w_accept) begin
         r_op_q    <= i_req_op;
         r_base_q  <= i_req_addr;
         r_len_q   <= i_req_len;
         r_idx     <= 4'h0;
         r_wdata_q <= i_req_data;
         r_rd_data <= 64'h0;
         r_err_q   <= 1'b0;
      end else if (r_state == S_XFER) begin
         // The bus is combinational, so read data is valid in the command cycle
         if (r_op_q != OP_DP_WRITE) begin
            r_rd_data[{r_idx, 2'b00} +: 4] <= i_bus_nibble_out;
         end
         if (i_bus_error) begin
            r_err_q <= 1'b1;
         end
         if (!w_last) begin
            r_idx <= r_idx + 4'h1;
         end
      end
   end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// tb/tb_hp48_bus_ctrl.sv - scoreboard bench for hp48_bus_ctrl
module tb_hp48_bus_ctrl;

   localparam logic [3:0] BUSCMD_NOP      = 4'h0;
   localparam logic [3:0] BUSCMD_PC_READ  = 4'h1;
   localparam logic [3:0] BUSCMD_DP_READ  = 4'h2;
   localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;

   typedef struct {
      int          cyc;
      logic [19:0] addr;
      logic [3:0]  cmd;
      logic [3:0]  nib;
   } bus_t;

   typedef struct {
      int          cyc;
      logic        err;
      logic [63:0] rd;
   } cmp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [1:0]  req_op;
   logic [19:0] req_addr;
   logic [3:0]  req_len;
   logic [63:0] req_data;
   logic        busy, done, error;
   logic [63:0] rd_data;
   logic [19:0] bus_address;
   logic [3:0]  bus_command;
   logic [3:0]  bus_nibble_in;
   logic [3:0]  bus_nibble_out;
   logic        bus_error;

   logic [3:0]  rd_off = 4'h0;
   logic        err_en = 1'b0;
   logic [19:0] err_addr = 20'h0;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n;
   bus_t bus_q[$];
   cmp_t cmp_q[$];
   bus_t be;
   cmp_t ce;

   hp48_bus_ctrl dut (
      .i_strobe        (clk),
      .i_reset         (rst_n),
      .i_req           (req),
      .i_req_op        (req_op),
      .i_req_addr      (req_addr),
      .i_req_len       (req_len),
      .i_req_data      (req_data),
      .o_busy          (busy),
      .o_done          (done),
      .o_error         (error),
      .o_rd_data       (rd_data),
      .o_bus_address   (bus_address),
      .o_bus_command   (bus_command),
      .o_bus_nibble_in (bus_nibble_in),
      .i_bus_nibble_out(bus_nibble_out),
      .i_bus_error     (bus_error)
   );

   // Bus model: read nibble derived from the address, error at one chosen address
   assign bus_nibble_out = bus_address[3:0] + rd_off;
   assign bus_error = err_en && (bus_command != BUSCMD_NOP) && (bus_address == err_addr);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_bus(input int c, input logic [19:0] a, input logic [3:0] cmd, input logic [3:0] nib);
      bus_t t;
      t.cyc = c; t.addr = a; t.cmd = cmd; t.nib = nib;
      bus_q.push_back(t);
   endtask

   task automatic push_cmp(input int c, input logic e, input logic [63:0] rd);
      cmp_t t;
      t.cyc = c; t.err = e; t.rd = rd;
      cmp_q.push_back(t);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {63'h0, busy}, 64'h0);
      check({tag, "_done"}, {63'h0, done}, 64'h0);
      check({tag, "_error"}, {63'h0, error}, 64'h0);
      check({tag, "_rd_data"}, rd_data, 64'h0);
      check({tag, "_addr"}, {44'h0, bus_address}, 64'h0);
      check({tag, "_cmd"}, {60'h0, bus_command}, {60'h0, BUSCMD_NOP});
      check({tag, "_nib_in"}, {60'h0, bus_nibble_in}, 64'h0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || done) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) begin
         checks++; errors++;
         $display("FAIL wait_idle: busy=%0b done=%0b after %0d cycles", busy, done, k);
      end
   endtask

   // Issue one request; returns the accept-edge cycle number
   task automatic issue(input logic [1:0] op, input logic [19:0] a, input logic [3:0] len,
                        input logic [63:0] d, output int acc);
      wait_idle();
      req = 1'b1; req_op = op; req_addr = a; req_len = len; req_data = d;
      @(posedge clk); #1;
      acc = cyc;
      req = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((bus_q.size() != 0 || cmp_q.size() != 0) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      if (bus_q.size() != 0 || cmp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s_drain: %0d bus and %0d done events outstanding, expected 0", tag, bus_q.size(), cmp_q.size());
         bus_q.delete();
         cmp_q.delete();
      end
   endtask

   // Monitor: compares every bus command and every done pulse against the queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_command != BUSCMD_NOP) begin
            checks++;
            if (bus_q.size() == 0) begin
               errors++;
               $display("FAIL bus_unexpected: cyc=%0d addr=%h cmd=%h, expected no command", cyc, bus_address, bus_command);
            end else begin
               be = bus_q.pop_front();
               if (be.cyc != cyc || be.addr !== bus_address || be.cmd !== bus_command || be.nib !== bus_nibble_in) begin
                  errors++;
                  $display("FAIL bus_cycle: got cyc=%0d addr=%h cmd=%h nib=%h expected cyc=%0d addr=%h cmd=%h nib=%h",
                           cyc, bus_address, bus_command, bus_nibble_in, be.cyc, be.addr, be.cmd, be.nib);
               end
            end
         end
         if (done) begin
            checks++;
            if (cmp_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: cyc=%0d, expected no done", cyc);
            end else begin
               ce = cmp_q.pop_front();
               if (ce.cyc != cyc || ce.err !== error || ce.rd !== rd_data || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL done_event: got cyc=%0d err=%0b rd=%h busy=%0b expected cyc=%0d err=%0b rd=%h busy=1",
                           cyc, error, rd_data, busy, ce.cyc, ce.err, ce.rd);
               end
            end
         end
         if (error && !done) begin
            checks++; errors++;
            $display("FAIL error_without_done: cyc=%0d error=1 expected 0", cyc);
         end
      end
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; req_op = 2'b00; req_addr = 20'h0; req_len = 4'h0; req_data = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // PC read at 0x00100, len 4, bus returns 1..5
      rd_off = 4'h1;
      issue(2'b00, 20'h00100, 4'd4, 64'h0, n);
      for (int i = 0; i < 5; i++) push_bus(n + i, 20'h00100 + 20'(i), BUSCMD_PC_READ, 4'h0);
      push_cmp(n + 5, 1'b0, 64'h0000_0000_0005_4321);
      drain("pc_read");
      wait_idle();
      check("rd_hold", rd_data, 64'h0000_0000_0005_4321);

      // DP write len 7, reset asserted while idx=3 is on the bus
      issue(2'b10, 20'h00300, 4'd7, 64'h0000_0000_8765_4321, n);
      for (int i = 0; i < 3; i++) push_bus(n + i, 20'h00300 + 20'(i), BUSCMD_DP_WRITE, 4'(i + 1));
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      drain("mid_rst");

      // DP write across the 20-bit wrap
      issue(2'b10, 20'hFFFFE, 4'd3, 64'h0000_0000_0000_DCBA, n);
      push_bus(n + 0, 20'hFFFFE, BUSCMD_DP_WRITE, 4'hA);
      push_bus(n + 1, 20'hFFFFF, BUSCMD_DP_WRITE, 4'hB);
      push_bus(n + 2, 20'h00000, BUSCMD_DP_WRITE, 4'hC);
      push_bus(n + 3, 20'h00001, BUSCMD_DP_WRITE, 4'hD);
      push_cmp(n + 4, 1'b0, 64'h0);
      drain("dp_write_wrap");

      // DP read len 15 with bus error on the 3rd bus cycle
      rd_off = 4'h0; err_en = 1'b1; err_addr = 20'h20002;
      issue(2'b01, 20'h20000, 4'd15, 64'h0, n);
`ifdef HP48_BUS_CTRL_ERR_ABORT_EN
      for (int i = 0; i < 3; i++) push_bus(n + i, 20'h20000 + 20'(i), BUSCMD_DP_READ, 4'h0);
      push_cmp(n + 3, 1'b1, 64'h0000_0000_0000_0210);
`else
      for (int i = 0; i < 16; i++) push_bus(n + i, 20'h20000 + 20'(i), BUSCMD_DP_READ, 4'h0);
      push_cmp(n + 16, 1'b1, 64'hFEDC_BA98_7654_3210);
`endif
      drain("dp_read_err");
      err_en = 1'b0;

      // req held high with len 0: one accept every 3 cycles
      rd_off = 4'h2;
      wait_idle();
      req = 1'b1; req_op = 2'b01; req_addr = 20'h00005; req_len = 4'd0; req_data = 64'h0;
      @(posedge clk); #1;
      n = cyc;
      for (int k = 0; k < 3; k++) begin
         push_bus(n + 3 * k, 20'h00005, BUSCMD_DP_READ, 4'h0);
         push_cmp(n + 3 * k + 1, 1'b0, 64'h7);
      end
      repeat (7) @(posedge clk);
      #1;
      req = 1'b0;
      drain("req_held");

      // Reserved op: done right after accept, no bus activity, rd_data cleared
      issue(2'b11, 20'h12345, 4'd5, 64'hFFFF, n);
      push_cmp(n, 1'b0, 64'h0);
      drain("reserved");
      repeat (3) @(posedge clk);
      #1;
      check("end_busy", {63'h0, busy}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hp48_bus_ctrl.md
# hp48_bus_ctrl

Nibble-serial transfer sequencer directly upstream of `hp48_bus`. Accepts one multi-nibble read or write request from the CPU core and issues one bus command per `strobe` cycle, at consecutive addresses. It assembles read nibbles into a 64-bit word and reports completion or bus error back to the core.

## Interface
- Parameters: none.
- `strobe` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `req_op` in 2: 00 PC read, 01 DP read, 10 DP write, 11 reserved (treated as no-op request).
- `req_addr` in 20: first nibble address.
- `req_len` in 4: nibble count minus one (0 = 1 nibble, 15 = 16 nibbles).
- `req_data` in 64: write data; nibble i = bits [4i+3:4i].
- `busy` out 1: high from the accepting edge until the DONE state ends.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: one-cycle pulse, coincident with `done`, when a bus error was seen.
- `rd_data` out 64: read result; nibble i in bits [4i+3:4i]; upper unused nibbles zero.
- `bus_address` out 20: to `hp48_bus.address`.
- `bus_command` out 4: to `hp48_bus.command`; `BUSCMD_NOP`, `BUSCMD_PC_READ`, `BUSCMD_DP_READ`, `BUSCMD_DP_WRITE` from `bus_commands.v`.
- `bus_nibble_in` out 4: to `hp48_bus.nibble_in`.
- `bus_nibble_out` in 4: from `hp48_bus.nibble_out`.
- `bus_error` in 1: from `hp48_bus.bus_error`.

## Operation
- States: IDLE, XFER, DONE. Registers: `op_q`, `base_q`, `len_q`, `idx` (4 b), `wdata_q`, `rd_data`, `err_q`.
- IDLE: `bus_command`=`BUSCMD_NOP`. If `req`=1 and `req_op`≠11, latch op/addr/len/data, clear `rd_data`, `err_q`, `idx`, and go to XFER. If `req_op`=11, go directly to DONE with no bus activity.
- XFER, each cycle: `bus_address` = (`base_q` + `idx`) mod 2^20, so 0xFFFFF+1 wraps to 0x00000. Command is selected by `op_q`. `bus_nibble_in` = `wdata_q` nibble `idx` for writes and 0 for reads.
- On each XFER edge for reads, `rd_data` nibble `idx` ← `bus_nibble_out`. Because the bus is combinational, data is captured in the same cycle the command is driven.
- If `idx`==`len_q`, go to DONE. Otherwise `idx`+1.
- `bus_error`=1 in XFER: set `err_q`. Abort behaviour is per Configuration.
- DONE (one cycle): `done`=1, `error`=`err_q`, `bus_command`=NOP, then IDLE. `req` is ignored in DONE.
- `rd_data` holds its value until the next accepted request.
- Reset (async, any state): state=IDLE. Outputs: `busy`=0, `done`=0, `error`=0, `rd_data`=0, `bus_address`=0, `bus_command`=`BUSCMD_NOP`, `bus_nibble_in`=0. An in-flight transfer is dropped silently, with no `done` pulse.

## Timing
- Bus outputs are combinational from registered state. No glitch-sensitive consumers.
- Request accepted at edge E0. First bus cycle is E0→E1. Last nibble is driven during cycle `len`+1 after acceptance.
- `done` is high in the cycle after the last bus cycle.
- Total latency from accept edge to `done` edge: `req_len`+2 cycles.
- The earliest next accept is the edge after DONE, i.e. back-to-back requests have a 1-cycle IDLE gap.
- `busy` falls together with `done`.

## Configuration
- `HP48_BUS_CTRL_ERR_ABORT_EN` defined: `bus_error` in XFER forces DONE on the next edge.
  - The erroring read nibble is still captured; remaining nibbles are not issued.
  - `error`=1 with `done`.
- Undefined: the transfer runs to `len_q`.
  - `err_q` is sticky for the transfer and is reported as `error`=1 with `done`.
  - Read nibbles fetched during error cycles are stored as returned.

## Test plan
- Reset mid-XFER (DP write, len 7, reset asserted at `idx`=3) -> all outputs at reset values immediately; no `done`; the next request runs normally.
- PC read, addr 0x00100, len 4, bus returns 1,2,3,4,5 -> addresses 0x00100..0x00104 with PC_READ; `rd_data`=0x0000_0000_0005_4321; `done` 6 cycles after accept; `error`=0.
- DP write, addr 0xFFFFE, len 3, data 0xDCBA -> addresses FFFFE, FFFFF, 00000, 00001; nibbles A, B, C, D; DP_WRITE each cycle.
- DP read, len 15, `bus_error` asserted on the 3rd bus cycle:
  - With `_EN`: `done`+`error` on the cycle after the error, and only 3 nibbles are issued.
  - Without `_EN`: all 16 nibbles are issued, then `error`=1.
- `req` held high continuously with len 0 -> transfers separated by one IDLE cycle; `req` asserted during XFER or DONE is not double-accepted.
- `req_op`=11 -> no non-NOP bus command; `done`=1 one cycle after accept; `rd_data`=0.
